// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial add/sub controller:
// FSM state encoding and the adder slice width.
package add_seq_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/add_seq_ctrl_rca.sv
// rca_8bit: 8-bit ripple-carry adder slice, the only adder in the datapath.
module rca_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   // Ripple the carry bit by bit through a single procedural variable.
   always_comb begin
      logic c;
      sum = '0;
      c   = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial W-bit adder/subtractor built around one 8-bit
// ripple slice. One operand byte is processed per cycle, LSB first.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the controller never drops rsp_valid or changes rsp_* until
// the consumer takes the result, and req_* are sampled only on accept.
// Optional feature: define ADD_SEQ_OVF_EN to add the rsp_ovf output
// (signed overflow, computed on the final beat).
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int NBEATS = 4,
   localparam int W = SLICE_W * NBEATS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   input  logic         req_sub,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_sum,
   output logic         rsp_cout,
`ifdef ADD_SEQ_OVF_EN
   output logic         rsp_ovf,
`endif
   output logic         busy
);

   localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;      // already inverted for subtraction
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
`ifdef ADD_SEQ_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
   logic               slice_co;

   // Select operand byte k (k = beat counter) onto the shared slice inputs.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int k = 0; k < NBEATS; k++) begin
         if (cnt_q == CW'(k)) begin
            slice_a = a_q[k*SLICE_W +: SLICE_W];
            slice_b = b_q[k*SLICE_W +: SLICE_W];
         end
      end
   end

   rca_8bit u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_s),
      .cout (slice_co)
   );

   // Next-state and datapath update: accept in IDLE, one beat per RUN cycle,
   // hold the result in DONE until it is taken.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_sub ? ~req_b : req_b;
               carry_d = req_sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = slice_co;
            for (int k = 0; k < NBEATS; k++) begin
               if (cnt_q == CW'(k)) sum_d[k*SLICE_W +: SLICE_W] = slice_s;
            end
            if (cnt_q == LAST_BEAT) begin
               cout_d  = slice_co;
`ifdef ADD_SEQ_OVF_EN
               // MSB carry-in ^ carry-out == signed overflow
               ovf_d   = a_q[W-1] ^ b_q[W-1] ^ slice_s[SLICE_W-1] ^ slice_co;
`endif
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
`ifdef ADD_SEQ_OVF_EN
   assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (NBEATS=4). A transaction-level
// model computes results with plain arithmetic and is compared against the
// DUT every cycle; directed scenarios add literal expectations.
// Honours ADD_SEQ_OVF_EN for the rsp_ovf port.
module tb_add_seq_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         req_sub = 1'b0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic         busy;
`ifdef ADD_SEQ_OVF_EN
   logic         rsp_ovf;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   add_seq_ctrl #(.NBEATS(NB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
`ifdef ADD_SEQ_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .busy      (busy)
   );

   // clock / cycle count
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // result = {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
      logic [W:0] u;
      longint sa, sb, r;
      logic cout, ovf;
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         u    = {1'b0, a} - {1'b0, b};
         cout = (a >= b);
         r    = sa - sb;
      end else begin
         u    = {1'b0, a} + {1'b0, b};
         cout = u[W];
         r    = sa + sb;
      end
      ovf = (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
      return {ovf, cout, u[W-1:0]};
   endfunction

   // transaction model: phase 0 = waiting, 1 = computing, 2 = result offered
   int             m_ph = 0;
   int             m_left = 0;
   bit             m_live = 0;
   logic [W+1:0]   m_last = '0;
   logic [W+1:0]   exp_q[$];
   logic [W-1:0]   got_q[$];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_ph = 0; m_left = 0; m_last = '0; exp_q.delete(); m_live = 1;
      end else begin
         case (m_ph)
            0: if (req_valid) begin
                  exp_q.push_back(model_op(req_a, req_b, req_sub));
                  m_left = NB; m_ph = 1;
               end
            1: begin m_left--; if (m_left == 0) m_ph = 2; end
            default: if (rsp_ready) begin m_last = exp_q.pop_front(); m_ph = 0; end
         endcase
      end
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      if (m_live) begin
         chk("m_req_ready", {63'd0, req_ready}, {63'd0, m_ph == 0});
         chk("m_busy",      {63'd0, busy},      {63'd0, m_ph != 0});
         chk("m_rsp_valid", {63'd0, rsp_valid}, {63'd0, m_ph == 2});
         if (m_ph != 1) begin
            logic [W+1:0] e;
            e = (m_ph == 2) ? exp_q[0] : m_last;
            chk("m_rsp_sum",  {{(64-W){1'b0}}, rsp_sum}, {{(64-W){1'b0}}, e[W-1:0]});
            chk("m_rsp_cout", {63'd0, rsp_cout}, {63'd0, e[W]});
`ifdef ADD_SEQ_OVF_EN
            chk("m_rsp_ovf",  {63'd0, rsp_ovf},  {63'd0, e[W+1]});
`endif
         end
         if (rsp_valid && rsp_ready && !rst) got_q.push_back(rsp_sum);
      end
   end

   // driver: one operation with literal expectations
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                         input int hold, input bit pulse);
      int n;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = W'($urandom); req_b = W'($urandom); req_sub = ~sub;
      n = 0;
      while (!rsp_valid && n < 40) begin
         req_valid = pulse && (n == 1);
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b0;
      chk("lat", 64'(n), 64'(NB));
      chk("sum",  {{(64-W){1'b0}}, rsp_sum}, {{(64-W){1'b0}}, e_sum});
      chk("cout", {63'd0, rsp_cout}, {63'd0, e_cout});
`ifdef ADD_SEQ_OVF_EN
      chk("ovf",  {63'd0, rsp_ovf},  {63'd0, e_ovf});
`else
      if (e_ovf !== e_ovf) chk("ovf_x", 64'd0, 64'd1);
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
         chk("hold_ready", {63'd0, req_ready}, 64'd0);
         chk("hold_sum",   {{(64-W){1'b0}}, rsp_sum}, {{(64-W){1'b0}}, e_sum});
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("post_valid", {63'd0, rsp_valid}, 64'd0);
      chk("post_ready", {63'd0, req_ready}, 64'd1);
   endtask

   logic [W-1:0] bb_a [3];
   logic [W-1:0] bb_b [3];
   logic [W-1:0] bb_e [3];
   int           acc_cyc [3];

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_sum",   {{(64-W){1'b0}}, rsp_sum}, 64'd0);
      chk("rst_busy",  {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, req_ready}, 64'd1);

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
      // stall 10 cycles, with a req_valid pulse during RUN
      run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 10, 1'b1);

      // reset in beat 2
      @(posedge clk); #1;
      req_a = 32'h1234_5678; req_b = 32'h1111_1111; req_sub = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_valid", {63'd0, rsp_valid}, 64'd0);
      chk("abort_sum",   {{(64-W){1'b0}}, rsp_sum}, 64'd0);
      chk("abort_cout",  {63'd0, rsp_cout}, 64'd0);
      chk("abort_busy",  {63'd0, busy}, 64'd0);
      chk("abort_ready", {63'd0, req_ready}, 64'd1);
      run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 0, 1'b0);

      // back-to-back
      bb_a[0] = 32'h0000_0010; bb_b[0] = 32'h0000_0020; bb_e[0] = 32'h0000_0030;
      bb_a[1] = 32'hDEAD_BEEF; bb_b[1] = 32'h0000_0001; bb_e[1] = 32'hDEAD_BEF0;
      bb_a[2] = 32'h00FF_00FF; bb_b[2] = 32'h0001_0001; bb_e[2] = 32'h0100_0100;
      got_q.delete();
      @(posedge clk); #1;
      rsp_ready = 1'b1; req_sub = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int n;
         req_a = bb_a[i]; req_b = bb_b[i];
         n = 0;
         while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
         chk("bb_wait", {63'd0, n >= 20}, 64'd0);
         @(posedge clk);
         acc_cyc[i] = cyc;
         #1;
      end
      req_valid = 1'b0;
      repeat (3 * (NB + 2)) @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bb_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'(NB + 2));
      chk("bb_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'(NB + 2));
      chk("bb_count", 64'(got_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < got_q.size())
            chk("bb_res", {{(64-W){1'b0}}, got_q[i]}, {{(64-W){1'b0}}, bb_e[i]});
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
